// File: rtl/alu_operand_stage.sv
// ID/EX pipeline slot feeding the ALU: captures a decoded instruction and
// resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_alu_src,
  input  logic [3:0]            in_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic [3:0]            alu_ctrl,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0]       rs1_q, rs1_d;
  logic [XLEN-1:0]       rs2_q, rs2_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic                  alu_src_q, alu_src_d;
  logic [3:0]            alu_ctrl_q, alu_ctrl_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic [XLEN-1:0]       fwd1_s, fwd2_s;

  // EX/MEM is the younger producer, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [XLEN-1:0]       stored,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_res,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_res
  );
    logic [XLEN-1:0] r;
    if (ex_we && (ex_rd == src) && (src != {REG_ADDR_W{1'b0}})) begin
      r = ex_res;
    end else if (wb_we && (wb_rd == src) && (src != {REG_ADDR_W{1'b0}})) begin
      r = wb_res;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  assign fwd1_s = fwd_sel(rs1_addr_q, rs1_q, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
  assign fwd2_s = fwd_sel(rs2_addr_q, rs2_q, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);

  // Slot next-state: flush > load > refresh operands while held > idle.
  always_comb begin
    valid_d     = valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
      rs1_d       = in_rs1_data;
      rs2_d       = in_rs2_data;
      imm_d       = in_imm;
      alu_src_d   = in_alu_src;
      alu_ctrl_d  = in_alu_ctrl;
      rd_d        = in_rd_addr;
      reg_write_d = in_reg_write;
    end else if (valid_q) begin
      // Capture forwarded values so operands survive the producer retiring.
      rs1_d = fwd1_s;
      rs2_d = fwd2_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= {REG_ADDR_W{1'b0}};
      rs2_addr_q  <= {REG_ADDR_W{1'b0}};
      rs1_q       <= {XLEN{1'b0}};
      rs2_q       <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= 4'd0;
      rd_q        <= {REG_ADDR_W{1'b0}};
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  // A bubble drives zeros so it executes as a harmless add with no writeback.
  always_comb begin
    op1           = {XLEN{1'b0}};
    op2           = {XLEN{1'b0}};
    alu_ctrl      = 4'd0;
    out_reg_write = 1'b0;
    if (valid_q) begin
      op1           = fwd1_s;
      op2           = alu_src_q ? imm_q : fwd2_s;
      alu_ctrl      = alu_ctrl_q;
      out_reg_write = reg_write_q;
    end else begin
      op1 = {XLEN{1'b0}};
    end
  end

  assign in_ready    = !stall;
  assign out_valid   = valid_q;
  assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a slot-level model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src, in_reg_write;
  logic [3:0]  in_alu_ctrl;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_reg_write;
  logic [31:0] op1, op2;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd_addr;

  int n_vec = 0;
  int n_err = 0;

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .op1(op1), .op2(op2), .alu_ctrl(alu_ctrl),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: x0 never forwarded, EX/MEM before MEM/WB, else stored data.
  function automatic logic [31:0] ref_fwd(input logic [4:0] s, input logic [31:0] d);
    if (s == 5'd0) return d;
    if (exmem_reg_write && exmem_rd == s) return exmem_result;
    if (memwb_reg_write && memwb_rd == s) return memwb_result;
    return d;
  endfunction

  // Model slot contents
  logic        m_valid, m_src, m_we;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [3:0]  m_ctrl;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_src <= 1'b0; m_we <= 1'b0; m_a1 <= 5'd0; m_a2 <= 5'd0;
      m_rd <= 5'd0; m_d1 <= 32'd0; m_d2 <= 32'd0; m_imm <= 32'd0; m_ctrl <= 4'd0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (!stall) begin
      m_valid <= in_valid; m_src <= in_alu_src; m_we <= in_reg_write;
      m_a1 <= in_rs1_addr; m_a2 <= in_rs2_addr; m_rd <= in_rd_addr;
      m_d1 <= in_rs1_data; m_d2 <= in_rs2_data; m_imm <= in_imm; m_ctrl <= in_alu_ctrl;
    end else if (m_valid) begin
      m_d1 <= ref_fwd(m_a1, m_d1);
      m_d2 <= ref_fwd(m_a2, m_d2);
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("m_op1", op1, m_valid ? ref_fwd(m_a1, m_d1) : 32'd0);
    chk("m_op2", op2, !m_valid ? 32'd0 : (m_src ? m_imm : ref_fwd(m_a2, m_d2)));
    chk("m_ctrl", {28'd0, alu_ctrl}, m_valid ? {28'd0, m_ctrl} : 32'd0);
    chk("m_we", {31'd0, out_reg_write}, {31'd0, m_valid & m_we});
    chk("m_rd", {27'd0, out_rd_addr}, {27'd0, m_rd});
    chk("m_ready", {31'd0, in_ready}, {31'd0, ~stall});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                           input logic src, input logic [3:0] ctrl, input logic [4:0] rd,
                           input logic we);
    in_valid = v; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
    in_imm = imm; in_alu_src = src; in_alu_ctrl = ctrl; in_rd_addr = rd; in_reg_write = we;
  endtask

  task automatic set_fwd(input logic exw, input logic [4:0] exr, input logic [31:0] exv,
                         input logic wbw, input logic [4:0] wbr, input logic [31:0] wbv);
    exmem_reg_write = exw; exmem_rd = exr; exmem_result = exv;
    memwb_reg_write = wbw; memwb_rd = wbr; memwb_result = wbv;
  endtask

  logic [3:0] codes [8];

  initial begin
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b0011; codes[3] = 4'b0100;
    codes[4] = 4'b0101; codes[5] = 4'b1101; codes[6] = 4'b0110; codes[7] = 4'b0111;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd1, 32'h75, 5'd2, 32'h39, 32'd0, 1'b0, 4'b1000, 5'd3, 1'b1);

    // Reset with a valid instruction offered
    step(); step(); look();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_rd", {27'd0, out_rd_addr}, 32'd0);
    step(); reset = 1'b0; look();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    step(); look();
    chk("cap_op1", op1, 32'h75);
    chk("cap_op2", op2, 32'h39);
    chk("cap_ctrl", {28'd0, alu_ctrl}, 32'h8);
    chk("cap_valid", {31'd0, out_valid}, 32'd1);
    chk("cap_rd", {27'd0, out_rd_addr}, 32'd3);

    in_alu_src = 1'b1; in_imm = 32'hFFFF_FFFC;
    step(); look();
    chk("imm_op2", op2, 32'hFFFF_FFFC);

    // Forwarding priority on a held instruction
    set_instr(1'b1, 5'd5, 32'h11, 5'd6, 32'h22, 32'd0, 1'b0, 4'b0000, 5'd8, 1'b1);
    step(); stall = 1'b1;
    set_instr(1'b1, 5'd9, 32'hBAD0, 5'd9, 32'hBAD1, 32'd0, 1'b0, 4'b0111, 5'd9, 1'b1);
    set_fwd(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h0000_BBBB);
    look();
    chk("fwd_exmem", op1, 32'hAAAA_0000);
    chk("fwd_ready", {31'd0, in_ready}, 32'd0);
    exmem_reg_write = 1'b0; #1;
    chk("fwd_memwb", op1, 32'h0000_BBBB);
    step(); stall = 1'b0;
    set_instr(1'b1, 5'd0, 32'h77, 5'd4, 32'h44, 32'd0, 1'b0, 4'b0000, 5'd1, 1'b1);
    set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    step(); look();
    chk("fwd_x0", op1, 32'h77);

    // Stall refresh: producer retires while the consumer is held
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd1, 32'h10, 5'd7, 32'h99, 32'd0, 1'b0, 4'b0100, 5'd2, 1'b1);
    step(); stall = 1'b1;
    set_instr(1'b1, 5'd3, 32'h3333, 5'd3, 32'h5555, 32'd0, 1'b0, 4'b1101, 5'd4, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    look();
    chk("stall_op2_fwd", op2, 32'h1234);
    step(); memwb_reg_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("stall_op2_held", op2, 32'h1234);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_ctrl", {28'd0, alu_ctrl}, 32'h4);
      step();
    end

    // Flush while stalled with a new instruction offered
    flush = 1'b1;
    step(); flush = 1'b0; look();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_op1", op1, 32'd0);
    chk("flush_op2", op2, 32'd0);
    chk("flush_we", {31'd0, out_reg_write}, 32'd0);
    stall = 1'b0; in_valid = 1'b0;
    step(); look();
    chk("flush_gone", {31'd0, out_valid}, 32'd0);

    // Bubble with stale nonzero data
    set_instr(1'b0, 5'd3, 32'hFFFF_0000, 5'd4, 32'h0000_FFFF, 32'h7, 1'b0, 4'b1000, 5'd5, 1'b1);
    step(); look();
    chk("bub_valid", {31'd0, out_valid}, 32'd0);
    chk("bub_op1", op1, 32'd0);
    chk("bub_op2", op2, 32'd0);
    chk("bub_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("bub_we", {31'd0, out_reg_write}, 32'd0);

    // ALU code pass-through with EX/MEM forwarding on even entries
    for (int i = 0; i < 8; i++) begin
      set_instr(1'b1, 5'(i + 1), 32'(100 + i), 5'(i + 9), 32'(200 + i), 32'd0, 1'b0,
                codes[i], 5'(i + 1), i[0]);
      set_fwd(i[0] == 1'b0, 5'(i + 9), 32'(i * 4096 + 1), 1'b0, 5'd0, 32'd0);
      step(); look();
      chk("code_ctrl", {28'd0, alu_ctrl}, {28'd0, codes[i]});
      chk("code_op2", op2, (i % 2 == 0) ? 32'(i * 4096 + 1) : 32'(200 + i));
    end

    // Reset asserted mid-stall empties the slot immediately
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd2, 32'hCAFE, 5'd3, 32'hF00D, 32'd0, 1'b0, 4'b0110, 5'd6, 1'b1);
    step(); stall = 1'b1; look();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1; #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_op1", op1, 32'd0);
    step(); reset = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step(); look();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the ALU; drives its op1, op2 and alu_ctrl inputs.
- Captures decoded instructions with a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports stall, with operand refresh while held, and flush.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register address width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts this cycle; equals !stall
- in_rs1_addr  input  REG_ADDR_W  source register 1 index
- in_rs2_addr  input  REG_ADDR_W  source register 2 index
- in_rs1_data  input  XLEN  register-file read data 1
- in_rs2_data  input  XLEN  register-file read data 2
- in_imm  input  XLEN  sign-extended immediate
- in_alu_src  input  1  1 = op2 takes immediate
- in_alu_ctrl  input  4  ALU operation code, passed through unchanged
- in_rd_addr  input  REG_ADDR_W  destination register
- in_reg_write  input  1  instruction writes rd
- stall  input  1  downstream hold
- flush  input  1  kill held and incoming instruction
- exmem_reg_write  input  1  EX/MEM write enable
- exmem_rd  input  REG_ADDR_W  EX/MEM destination
- exmem_result  input  XLEN  EX/MEM result
- memwb_reg_write  input  1  MEM/WB write enable
- memwb_rd  input  REG_ADDR_W  MEM/WB destination
- memwb_result  input  XLEN  MEM/WB result
- out_valid  output  1  stage holds a live instruction
- op1  output  XLEN  ALU operand 1
- op2  output  XLEN  ALU operand 2
- alu_ctrl  output  4  ALU operation
- out_rd_addr  output  REG_ADDR_W  destination passed downstream
- out_reg_write  output  1  write enable passed downstream; 0 when !out_valid

Behaviour:
- Reset: asynchronous; all state registers cleared. While reset is asserted: out_valid=0, op1=0, op2=0, alu_ctrl=0, out_rd_addr=0, out_reg_write=0. in_ready follows stall.
- State is a single slot: EMPTY (valid_q=0) or HELD (valid_q=1).
- Register update priority at each clock edge:
  - flush: valid_q <- 0; the incoming instruction is dropped even if in_valid=1 and stall=0.
  - else stall=0: all fields load from the inputs; valid_q <- in_valid. When in_valid=0 a bubble is loaded.
  - else stall=1 and valid_q=1: fields hold, except rs1_q/rs2_q, which are overwritten with the current forwarded values (fwd1/fwd2). This keeps operands correct after the producing instruction retires.
  - else (stall=1, EMPTY): no change.
- Forwarding is combinational on the stored fields. For source register s with stored data d:
  - If exmem_reg_write and exmem_rd==s and s!=0: use exmem_result.
  - Else if memwb_reg_write and memwb_rd==s and s!=0: use memwb_result.
  - Else: use d.
  - EX/MEM beats MEM/WB when both match. Register x0 is never forwarded.
- Output mux:
  - op1 = fwd1.
  - op2 = alu_src_q ? imm_q : fwd2. Forwarding does not apply to the immediate.
  - When out_valid=0: op1, op2, alu_ctrl and out_reg_write are forced to 0, so a bubble executes as a harmless add.
- Latency: an input accepted at edge N appears on the outputs after edge N, i.e. one cycle.
- Forwarding paths are zero-latency, from port to output.
- Simultaneous stall and flush: flush wins and out_valid becomes 0 on the next edge.
- A reset asserted mid-stall discards the held instruction immediately.
- alu_ctrl is passed through unchanged. Codes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.

Test Plan:
- Reset:
  - Stimulus: assert reset with stall=0 and in_valid=1.
  - Required: all outputs 0, out_valid=0.
  - Stimulus: deassert reset.
  - Required: first accepted instruction appears after exactly one clock.
- Basic capture:
  - Stimulus: rs1_data=0x75, rs2_data=0x39, alu_src=0, alu_ctrl=1000, rd=3, reg_write=1, no forwarding.
  - Required: next cycle op1=0x75, op2=0x39, alu_ctrl=1000, out_valid=1.
  - Stimulus: repeat with alu_src=1, imm=0xFFFFFFFC.
  - Required: op2=0xFFFFFFFC.
- Forwarding priority:
  - Stimulus: held rs1=5; exmem(5, 0xAAAA0000, we=1) and memwb(5, 0x0000BBBB, we=1) both active.
  - Required: op1=0xAAAA0000.
  - Stimulus: drop exmem_reg_write.
  - Required: op1=0x0000BBBB.
  - Stimulus: rs1=0 with exmem_rd=0.
  - Required: op1 equals stored data.
- Stall refresh:
  - Stimulus: hold instruction with rs2=7 under stall; memwb forwards 0x1234 to x7 for one cycle, then memwb_reg_write=0.
  - Required: op2 stays 0x1234 for the rest of the stall; in_ready=0 throughout; new input ignored.
- Flush:
  - Stimulus: valid instruction held, then flush=1 with in_valid=1 and stall=1.
  - Required: next cycle out_valid=0, op1=op2=0, out_reg_write=0; incoming instruction never appears.
- Bubble:
  - Stimulus: in_valid=0, stall=0.
  - Required: out_valid=0 and outputs zero the next cycle, regardless of stale input data.
